// File: rtl/dmem_access_unit.sv
// ---------------------------------------------------------------------------
// dmem_access_unit
//
// Load/store initiator between the MEM pipeline stage and a single-port data
// RAM. One byte, halfword or word access is accepted per request. The unit
// generates big-endian byte selects and replicated store data, stalls the
// pipeline for the whole access, and returns aligned, sign- or zero-extended
// load data. Misaligned requests are answered without a RAM cycle.
//
// Parameters:
//   WAIT_CYCLES  extra RAM access cycles beyond the first (0..15)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   req_i        access request (sampled only while idle)
//   we_i         1 = store, 0 = load
//   size_i       0 = byte, 1 = half, 2 = word, 3 = reserved
//   sign_ext_i   loads: 1 = sign-extend, 0 = zero-extend
//   addr_i       byte address
//   wdata_i      right-aligned store data
//   stall_o      pipeline stall request
//   ready_o      one-cycle completion pulse
//   rdata_o      extended load data, valid with ready_o
//   misalign_o   misaligned-access flag, valid with ready_o
//   ram_ce_o     RAM chip enable
//   ram_we_o     RAM write enable
//   ram_sel_o    RAM byte enables, bit 3 = data[31:24]
//   ram_addr_o   RAM word address (low two bits zero)
//   ram_data_o   RAM write data
//   ram_data_i   RAM read data, combinational in the same cycle
// ---------------------------------------------------------------------------
module dmem_access_unit #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        ready_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [3:0]  cnt;
    logic        cap_we;
    logic [1:0]  cap_size;
    logic        cap_sign;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [31:0] rdata_q;
    logic        misalign_q;

    logic        req_misalign;
    logic [3:0]  sel;
    logic [31:0] store_data;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data;

    // Alignment check on the live request; reserved size is always rejected.
    always_comb begin
        case (size_i)
            2'd0:    req_misalign = 1'b0;
            2'd1:    req_misalign = addr_i[0];
            2'd2:    req_misalign = |addr_i[1:0];
            default: req_misalign = 1'b1;
        endcase
    end

    // Big-endian byte selects: lowest address maps to data[31:24].
    always_comb begin
        case (cap_size)
            2'd0:    sel = 4'b1000 >> cap_addr[1:0];
            2'd1:    sel = cap_addr[1] ? 4'b0011 : 4'b1100;
            default: sel = 4'b1111;
        endcase
    end

    // Replicating store data lets the RAM pick whichever lane sel enables.
    always_comb begin
        case (cap_size)
            2'd0:    store_data = {4{cap_wdata[7:0]}};
            2'd1:    store_data = {2{cap_wdata[15:0]}};
            default: store_data = cap_wdata;
        endcase
    end

    // Lane extraction and extension of the combinational RAM read data.
    always_comb begin
        case (cap_addr[1:0])
            2'd0:    lane_b = ram_data_i[31:24];
            2'd1:    lane_b = ram_data_i[23:16];
            2'd2:    lane_b = ram_data_i[15:8];
            default: lane_b = ram_data_i[7:0];
        endcase
        lane_h = cap_addr[1] ? ram_data_i[15:0] : ram_data_i[31:16];
        case (cap_size)
            2'd0:    load_data = {{24{cap_sign & lane_b[7]}}, lane_b};
            2'd1:    load_data = {{16{cap_sign & lane_h[15]}}, lane_h};
            default: load_data = ram_data_i;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_i) state_next = req_misalign ? DONE : ACCESS;
            ACCESS:  if (cnt == 4'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every register here is cleared so that the response path
            // is deterministic after reset, even though the FSM would
            // overwrite them before use.
            cnt        <= 4'd0;
            cap_we     <= 1'b0;
            cap_size   <= 2'd0;
            cap_sign   <= 1'b0;
            cap_addr   <= 32'd0;
            cap_wdata  <= 32'd0;
            rdata_q    <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i) begin
                        cap_we     <= we_i;
                        cap_size   <= size_i;
                        cap_sign   <= sign_ext_i;
                        cap_addr   <= addr_i;
                        cap_wdata  <= wdata_i;
                        misalign_q <= req_misalign;
                        rdata_q    <= 32'd0;
                        cnt        <= 4'(WAIT_CYCLES);
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        rdata_q <= cap_we ? 32'd0 : load_data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        ready_o    = 1'b0;
        rdata_o    = 32'd0;
        misalign_o = 1'b0;
        ram_ce_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_sel_o  = 4'd0;
        ram_addr_o = 32'd0;
        ram_data_o = 32'd0;
        case (state)
            ACCESS: begin
                ram_ce_o   = 1'b1;
                ram_we_o   = cap_we;
                ram_sel_o  = sel;
                ram_addr_o = {cap_addr[31:2], 2'b00};
                ram_data_o = store_data;
            end
            DONE: begin
                ready_o    = 1'b1;
                rdata_o    = rdata_q;
                misalign_o = misalign_q;
            end
            default: ;
        endcase
    end

    // The request term is combinational so the pipeline freezes in the very
    // cycle it asks; it is masked during reset so all outputs read 0.
    assign stall_o = !rst && ((state == ACCESS) || ((state == IDLE) && req_i));

endmodule

// File: tb/tb_dmem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_unit
//
// Two instances (WAIT_CYCLES = 0 and 3), each attached to its own RAM model.
// A byte-addressed reference memory predicts load data, store effects,
// selects, latency and stall length; a monitor compares every RAM cycle and
// completion pulse against a per-instance expectation queue.
// ---------------------------------------------------------------------------
module tb_dmem_access_unit;

    localparam int W1 = 3;

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wrep;
        int          ready_cyc;
        int          ce_n;
        int          we_n;
        int          st_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst        [2];
    logic        req        [2];
    logic        we         [2];
    logic [1:0]  size       [2];
    logic        sign_ext   [2];
    logic [31:0] addr       [2];
    logic [31:0] wdata      [2];
    logic        stall      [2];
    logic        ready      [2];
    logic [31:0] rdata      [2];
    logic        misalign   [2];
    logic        ram_ce     [2];
    logic        ram_we     [2];
    logic [3:0]  ram_sel    [2];
    logic [31:0] ram_addr   [2];
    logic [31:0] ram_wd     [2];
    logic [31:0] ram_rd     [2];

    logic [31:0] init_mem   [128];
    logic [31:0] ram_mem    [2][128];
    logic [31:0] model_mem  [2][128];
    logic        preload;

    exp_t        sb_q       [2][$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_access_unit #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst[0]), .req_i(req[0]), .we_i(we[0]), .size_i(size[0]),
        .sign_ext_i(sign_ext[0]), .addr_i(addr[0]), .wdata_i(wdata[0]),
        .stall_o(stall[0]), .ready_o(ready[0]), .rdata_o(rdata[0]),
        .misalign_o(misalign[0]), .ram_ce_o(ram_ce[0]), .ram_we_o(ram_we[0]),
        .ram_sel_o(ram_sel[0]), .ram_addr_o(ram_addr[0]), .ram_data_o(ram_wd[0]),
        .ram_data_i(ram_rd[0])
    );

    dmem_access_unit #(.WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .rst(rst[1]), .req_i(req[1]), .we_i(we[1]), .size_i(size[1]),
        .sign_ext_i(sign_ext[1]), .addr_i(addr[1]), .wdata_i(wdata[1]),
        .stall_o(stall[1]), .ready_o(ready[1]), .rdata_o(rdata[1]),
        .misalign_o(misalign[1]), .ram_ce_o(ram_ce[1]), .ram_we_o(ram_we[1]),
        .ram_sel_o(ram_sel[1]), .ram_addr_o(ram_addr[1]), .ram_data_o(ram_wd[1]),
        .ram_data_i(ram_rd[1])
    );

    // RAM models: combinational read, byte-enabled write on the rising edge.
    assign ram_rd[0] = ram_mem[0][ram_addr[0][8:2]];
    assign ram_rd[1] = ram_mem[1][ram_addr[1][8:2]];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (preload) begin
                for (int i = 0; i < 128; i++) ram_mem[d][i] <= init_mem[i];
            end else if (ram_ce[d] && ram_we[d]) begin
                for (int k = 0; k < 4; k++)
                    if (ram_sel[d][k])
                        ram_mem[d][ram_addr[d][8:2]][8*k +: 8] <= ram_wd[d][8*k +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : W1;
    endfunction

    // Reference model: treats memory as a big-endian byte array and applies
    // the access byte by byte; also predicts RAM-side activity and timing.
    function automatic exp_t model_access(input int d, input logic w, input logic [1:0] sz,
                                          input logic sg, input logic [31:0] a,
                                          input logic [31:0] wd);
        exp_t        e;
        int          nb;
        logic [31:0] ba;
        logic [31:0] val;
        logic [31:0] word;
        logic [7:0]  b;
        e    = '0;
        nb   = 1 << sz;
        e.mis  = (sz == 2'd3) || ((a % nb) != 0);
        e.we   = w;
        e.addr = {a[31:2], 2'b00};
        e.ce_n = e.mis ? 0 : wait_of(d) + 1;
        e.we_n = (!e.mis && w) ? wait_of(d) + 1 : 0;
        e.st_n = e.mis ? 1 : wait_of(d) + 2;
        if (!e.mis) begin
            val = 32'd0;
            for (int k = 0; k < nb; k++) begin
                ba = a + k;
                e.sel[3 - ba[1:0]] = 1'b1;
                word = model_mem[d][ba[8:2]];
                if (w) begin
                    b = 8'(wd >> (8 * (nb - 1 - k)));
                    word[8 * (3 - ba[1:0]) +: 8] = b;
                    model_mem[d][ba[8:2]] = word;
                end else begin
                    b = 8'(word >> (8 * (3 - ba[1:0])));
                    val = (val << 8) | {24'd0, b};
                end
            end
            if (!w && sg && nb < 4 && val[8*nb-1])
                val = val | ~((32'd1 << (8 * nb)) - 32'd1);
            e.rdata = w ? 32'd0 : val;
            e.wrep  = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;
        end
        return e;
    endfunction

    task automatic drive(input int d, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        we[d] = w; size[d] = sz; sign_ext[d] = sg; addr[d] = a; wdata[d] = wd;
    endtask

    task automatic scramble(input int d);
        drive(d, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
    endtask

    // One access: issue in an idle cycle, drop the request after the accept
    // edge, scramble the inputs, and wait (bounded) for the completion pulse.
    task automatic issue(input int d, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        bit   got;
        @(posedge clk); #1;
        e = model_access(d, w, sz, sg, a, wd);
        e.ready_cyc = cyc + (e.mis ? 1 : wait_of(d) + 2);
        sb_q[d].push_back(e);
        drive(d, w, sz, sg, a, wd);
        req[d] = 1'b1;
        @(posedge clk); #1;
        req[d] = 1'b0;
        scramble(d);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (ready[d]) got = 1'b1;
        end
        check($sformatf("d%0d_ready_seen", d), {31'd0, got}, 32'd1);
    endtask

    // Request held high across two accesses: the second accept happens only
    // in the idle cycle after the first completion.
    task automatic back_to_back(input int d);
        exp_t ea;
        exp_t eb;
        int   seen;
        @(posedge clk); #1;
        ea = model_access(d, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
        ea.ready_cyc = cyc + wait_of(d) + 2;
        eb = model_access(d, 1'b0, 2'd0, 1'b1, 32'h101, 32'd0);
        eb.ready_cyc = ea.ready_cyc + 1 + wait_of(d) + 2;
        sb_q[d].push_back(ea);
        sb_q[d].push_back(eb);
        drive(d, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
        req[d] = 1'b1;
        @(posedge clk); #1;
        drive(d, 1'b0, 2'd0, 1'b1, 32'h101, 32'd0);
        seen = 0;
        for (int i = 0; i < 80 && seen < 2; i++) begin
            @(negedge clk);
            if (ready[d]) seen++;
        end
        #1 req[d] = 1'b0;
        check($sformatf("d%0d_b2b_ready_count", d), seen, 2);
    endtask

    // Monitor: checks every RAM cycle against the in-flight expectation and
    // every completion pulse against the queue head.
    int ce_n [2];
    int we_n [2];
    int st_n [2];
    initial begin
        exp_t h;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst[d]) begin
                    ce_n[d] = 0; we_n[d] = 0; st_n[d] = 0;
                end else begin
                    if (stall[d]) st_n[d]++;
                    if (ram_ce[d]) begin
                        ce_n[d]++;
                        if (ram_we[d]) we_n[d]++;
                        if (sb_q[d].size() > 0) begin
                            h = sb_q[d][0];
                            check($sformatf("d%0d_ram_addr", d), ram_addr[d], h.addr);
                            check($sformatf("d%0d_ram_sel", d), {28'd0, ram_sel[d]}, {28'd0, h.sel});
                            check($sformatf("d%0d_ram_we", d), {31'd0, ram_we[d]}, {31'd0, h.we});
                            if (h.we) check($sformatf("d%0d_ram_wdata", d), ram_wd[d], h.wrep);
                        end
                    end
                    if (ready[d]) begin
                        if (sb_q[d].size() == 0) begin
                            check($sformatf("d%0d_unexpected_ready", d), 32'd1, 32'd0);
                        end else begin
                            h = sb_q[d].pop_front();
                            check($sformatf("d%0d_rdata", d), rdata[d], h.rdata);
                            check($sformatf("d%0d_misalign", d), {31'd0, misalign[d]}, {31'd0, h.mis});
                            check($sformatf("d%0d_ready_cycle", d), cyc, h.ready_cyc);
                            check($sformatf("d%0d_ce_cycles", d), ce_n[d], h.ce_n);
                            check($sformatf("d%0d_we_cycles", d), we_n[d], h.we_n);
                            check($sformatf("d%0d_stall_cycles", d), st_n[d], h.st_n);
                            check($sformatf("d%0d_stall_in_done", d), {31'd0, stall[d]}, 32'd0);
                        end
                        ce_n[d] = 0; we_n[d] = 0; st_n[d] = 0;
                    end
                end
            end
        end
    end

    task automatic reset_mid_access(input int d);
        bit   any_ready;
        @(posedge clk); #1;
        drive(d, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
        req[d] = 1'b1;
        @(posedge clk); #1;
        req[d] = 1'b0;
        @(posedge clk); #1;
        check("rst_pre_ce", {31'd0, ram_ce[d]}, 32'd1);
        rst[d] = 1'b1;
        #1;
        check("rst_ce", {31'd0, ram_ce[d]}, 32'd0);
        check("rst_we", {31'd0, ram_we[d]}, 32'd0);
        check("rst_sel", {28'd0, ram_sel[d]}, 32'd0);
        check("rst_addr", ram_addr[d], 32'd0);
        check("rst_wdata", ram_wd[d], 32'd0);
        check("rst_stall", {31'd0, stall[d]}, 32'd0);
        check("rst_ready", {31'd0, ready[d]}, 32'd0);
        check("rst_rdata", rdata[d], 32'd0);
        check("rst_misalign", {31'd0, misalign[d]}, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst[d] = 1'b0;
        any_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready[d]) any_ready = 1'b1;
        end
        check("rst_no_ready", {31'd0, any_ready}, 32'd0);
    endtask

    initial begin
        preload = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            drive(d, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
            req[d] = 1'b1;
        end
        for (int i = 0; i < 128; i++) init_mem[i] = $urandom;
        init_mem[64] = 32'h8192A3B4;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 128; i++) model_mem[d][i] = init_mem[i];

        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_reset_stall", d), {31'd0, stall[d]}, 32'd0);
            check($sformatf("d%0d_reset_ready", d), {31'd0, ready[d]}, 32'd0);
            check($sformatf("d%0d_reset_ce", d), {31'd0, ram_ce[d]}, 32'd0);
            check($sformatf("d%0d_reset_rdata", d), rdata[d], 32'd0);
            req[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Zero-wait instance: directed cases around the preloaded word.
        issue(0, 1'b0, 2'd0, 1'b1, 32'h101, 32'd0);
        issue(0, 1'b0, 2'd1, 1'b0, 32'h102, 32'd0);
        issue(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
        issue(0, 1'b1, 2'd0, 1'b0, 32'h103, 32'h000000CC);
        issue(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
        issue(0, 1'b0, 2'd2, 1'b0, 32'h102, 32'd0);
        issue(0, 1'b0, 2'd3, 1'b0, 32'h100, 32'd0);
        issue(0, 1'b0, 2'd1, 1'b1, 32'h101, 32'd0);
        issue(0, 1'b1, 2'd1, 1'b0, 32'h10E, 32'h1234F00D);
        issue(0, 1'b0, 2'd1, 1'b1, 32'h10E, 32'd0);

        // Three-wait instance: latency, back-to-back, reset mid-access.
        issue(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
        back_to_back(1);
        reset_mid_access(1);
        issue(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);

        // Randomized mix on both instances.
        for (int n = 0; n < 60; n++) begin
            for (int d = 0; d < 2; d++) begin
                issue(d, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                      32'($urandom_range(0, 32'h1FF)), $urandom);
            end
        end

        repeat (3) @(posedge clk);
        for (int d = 0; d < 2; d++)
            check($sformatf("d%0d_queue_drained", d), sb_q[d].size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
